multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 96 +++++++++
 tb/tb_multicycle_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle FSM controller for a small RISC-V subset (R/I ALU ops, LOAD, STORE).
// Strobes follow the state and decode registers; only the STORE-exit pc_en also looks at mem_ready.
module multicycle_ctrl #(
    parameter logic [31:0] RETIRED_RST = '0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic        mem_ready,
    output logic        ir_en,
    output logic        pc_en,
    output logic        reg_write,
    output logic        mem2reg,
    output logic        alu_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  alu_cc,
    output logic        illegal,
    output logic [31:0] retired
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
    typedef enum logic [1:0] {C_ALU, C_LOAD, C_STORE} cls_t;

    state_t      state_q, state_d;
    cls_t        cls_q, cls_d;
    logic [3:0]  cc_q, cc_d;
    logic        src_q, src_d;
    logic [31:0] retired_q, retired_d;

    logic       is_r, is_i, is_ld, is_st, f3_ok, f7_ok, legal;
    logic [3:0] dec_cc;

    assign is_r   = opcode == 7'b0110011;
    assign is_i   = opcode == 7'b0010011;
    assign is_ld  = opcode == 7'b0000011;
    assign is_st  = opcode == 7'b0100011;
    assign f7_ok  = funct7 == 7'b0000000 || funct7 == 7'b0100000;
    assign f3_ok  = funct3 inside {3'b000, 3'b111, 3'b110, 3'b100, 3'b010};
    assign legal  = is_ld || is_st || ((is_r || is_i) && f3_ok && (!is_r || f7_ok));
    // funct7 selects SUB only for R-type; on I-type those bits belong to the immediate
    assign dec_cc = (is_ld || is_st)  ? 4'b0010 :
                    funct3 == 3'b000  ? ((is_r && funct7 == 7'b0100000) ? 4'b0110 : 4'b0010) :
                    funct3 == 3'b111  ? 4'b0000 :
                    funct3 == 3'b110  ? 4'b0001 :
                    funct3 == 3'b100  ? 4'b1101 : 4'b0111;

    assign ir_en     = state_q == FETCH;
    assign reg_write = state_q == WB;
    assign mem2reg   = state_q == WB && cls_q == C_LOAD;
    assign mem_read  = state_q == MEM && cls_q == C_LOAD;
    assign mem_write = state_q == MEM && cls_q == C_STORE;
    assign pc_en     = state_q == WB || (mem_write && mem_ready);
    assign alu_cc    = cc_q;
    assign alu_src   = src_q;
    assign illegal   = state_q == TRAP;
    assign retired   = retired_q;

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        cc_d      = cc_q;
        src_d     = src_q;
        retired_d = pc_en ? retired_q + 32'd1 : retired_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                state_d = legal ? EXEC : TRAP;
                cls_d   = is_ld ? C_LOAD : is_st ? C_STORE : C_ALU;
                cc_d    = dec_cc;
                src_d   = !is_r;
            end
            EXEC:   state_d = cls_q == C_ALU ? WB : MEM;
            MEM:    state_d = !mem_ready ? MEM : cls_q == C_LOAD ? WB : FETCH;
            WB:     state_d = FETCH;
            default: state_d = TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            cls_q     <= C_ALU;
            cc_q      <= '0;
            src_q     <= 1'b0;
            retired_q <= RETIRED_RST;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            cc_q      <= cc_d;
            src_q     <= src_d;
            retired_q <= retired_d;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench; each instruction pushes its expected profile, popped when the DUT returns to FETCH.
// A second instance preset near the top of the retired range exercises the counter wrap.
module tb_multicycle_ctrl;
    logic        clk = 0, reset = 1, mem_ready = 0;
    logic [6:0]  opcode = '0, funct7 = '0;
    logic [2:0]  funct3 = '0;
    logic        ir_en, pc_en, reg_write, mem2reg, alu_src, mem_read, mem_write, illegal;
    logic [3:0]  alu_cc;
    logic [31:0] retired;
    logic        ir_en2, pc_en2, reg_write2, mem2reg2, alu_src2, mem_read2, mem_write2, illegal2;
    logic [3:0]  alu_cc2;
    logic [31:0] retired2;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .mem_ready(mem_ready), .ir_en(ir_en), .pc_en(pc_en), .reg_write(reg_write),
        .mem2reg(mem2reg), .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
        .alu_cc(alu_cc), .illegal(illegal), .retired(retired)
    );

    multicycle_ctrl #(.RETIRED_RST(32'hFFFF_FFFF)) dut_wrap (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .mem_ready(mem_ready), .ir_en(ir_en2), .pc_en(pc_en2), .reg_write(reg_write2),
        .mem2reg(mem2reg2), .alu_src(alu_src2), .mem_read(mem_read2), .mem_write(mem_write2),
        .alu_cc(alu_cc2), .illegal(illegal2), .retired(retired2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cycles, rw, mr, mw, pc, ir;
        logic        m2r, src, ill;
        logic [3:0]  cc;
        logic [31:0] ret;
    } prof_t;

    prof_t       sb[$];
    int          checks = 0, failures = 0;
    logic [31:0] exp_ret = '0;

    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_TRAP = 3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1;
        mem_ready = 1;
        step;
        reset = 0;
        mem_ready = 0;
        exp_ret = '0;
        check("rst_ir_en", 32'(ir_en), 1);
        check("rst_strobes", 32'({pc_en, reg_write, mem2reg, alu_src, mem_read, mem_write}), 0);
        check("rst_alu_cc", 32'(alu_cc), 0);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_retired", retired, 0);
        check("rst_retired_preset", retired2, 32'hFFFF_FFFF);
    endtask

    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input int waits, input int kind, input logic [3:0] cc, input logic src);
        prof_t e, o;
        int cyc, mc, bad;
        e.ill    = kind == K_TRAP;
        e.cycles = kind == K_ALU ? 4 : kind == K_LOAD ? 5 + waits : kind == K_STORE ? 4 + waits : 16;
        e.rw     = (kind == K_ALU || kind == K_LOAD) ? 1 : 0;
        e.mr     = kind == K_LOAD ? waits + 1 : 0;
        e.mw     = kind == K_STORE ? waits + 1 : 0;
        e.pc     = e.ill ? 0 : 1;
        e.ir     = 1;
        e.m2r    = kind == K_LOAD;
        e.cc     = cc;
        e.src    = src;
        if (!e.ill) exp_ret = exp_ret + 32'd1;
        e.ret    = exp_ret;
        sb.push_back(e);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
        o.rw = 0; o.mr = 0; o.mw = 0; o.pc = 0; o.ir = 0;
        o.m2r = 0; o.cc = '0; o.src = 0;
        cyc = 0; mc = 0; bad = 0;
        do begin
            if (mem_read || mem_write) begin
                mem_ready = mc == waits;
                mc++;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            o.rw += int'(reg_write);
            o.mr += int'(mem_read);
            o.mw += int'(mem_write);
            o.pc += int'(pc_en);
            o.ir += int'(ir_en);
            if (reg_write) o.m2r = mem2reg;
            if (cyc == 2) begin
                o.cc  = alu_cc;
                o.src = alu_src;
            end
            if (int'(reg_write) + int'(mem_read) + int'(mem_write) > 1) bad++;
            if (cyc < 2 && (reg_write || mem_read || mem_write || pc_en)) bad++;
            step;
            cyc++;
        end while (!ir_en && cyc < 16);
        o.cycles = cyc;
        o.ill    = illegal;
        o.ret    = retired;
        e = sb.pop_front();
        check($sformatf("cycles_op%0h", op), o.cycles, e.cycles);
        check("reg_write_cycles", o.rw, e.rw);
        check("mem_read_cycles", o.mr, e.mr);
        check("mem_write_cycles", o.mw, e.mw);
        check("pc_en_cycles", o.pc, e.pc);
        check("ir_en_cycles", o.ir, e.ir);
        check("illegal", 32'(o.ill), 32'(e.ill));
        check("retired", o.ret, e.ret);
        check("strobe_excl_scope", bad, 0);
        if (!e.ill) begin
            check($sformatf("alu_cc_op%0h_f3%0h", op, f3), 32'(o.cc), 32'(e.cc));
            check("alu_src", 32'(o.src), 32'(e.src));
            if (e.rw != 0) check("mem2reg", 32'(o.m2r), 32'(e.m2r));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        do_reset;
        run(7'b0110011, 3'b000, 7'b0100000, 0, K_ALU, 4'b0110, 1'b0);
        check("retired_wrap", retired2, 32'h0);
        run(7'b0010011, 3'b000, 7'b0100000, 0, K_ALU, 4'b0010, 1'b1);
        run(7'b0110011, 3'b111, 7'b0000000, 0, K_ALU, 4'b0000, 1'b0);
        run(7'b0010011, 3'b110, 7'b0000000, 0, K_ALU, 4'b0001, 1'b1);
        run(7'b0110011, 3'b100, 7'b0000000, 0, K_ALU, 4'b1101, 1'b0);
        run(7'b0010011, 3'b010, 7'b0000000, 0, K_ALU, 4'b0111, 1'b1);
        run(7'b0110011, 3'b000, 7'b0000000, 0, K_ALU, 4'b0010, 1'b0);
        run(7'b0000011, 3'b010, 7'b0000000, 3, K_LOAD, 4'b0010, 1'b1);
        run(7'b0100011, 3'b111, 7'b0100000, 0, K_STORE, 4'b0010, 1'b1);
        run(7'b0100011, 3'b010, 7'b0000000, 2, K_STORE, 4'b0010, 1'b1);
        run(7'b0000011, 3'b000, 7'b0000000, 0, K_LOAD, 4'b0010, 1'b1);
        // abandon a LOAD while it is stalled in MEM
        opcode = 7'b0000011;
        funct3 = 3'b010;
        mem_ready = 0;
        repeat (4) step;
        check("mid_mem_read", 32'(mem_read), 1);
        reset = 1;
        step;
        reset = 0;
        exp_ret = '0;
        check("abort_ir_en", 32'(ir_en), 1);
        check("abort_mem_read", 32'(mem_read), 0);
        check("abort_reg_write", 32'(reg_write), 0);
        check("abort_pc_en", 32'(pc_en), 0);
        check("abort_retired", retired, 0);
        run(7'b0110011, 3'b110, 7'b0000000, 0, K_ALU, 4'b0001, 1'b0);
        run(7'b1111111, 3'b000, 7'b0000000, 0, K_TRAP, 4'b0000, 1'b0);
        do_reset;
        run(7'b0010011, 3'b001, 7'b0000000, 0, K_TRAP, 4'b0000, 1'b0);
        do_reset;
        run(7'b0110011, 3'b000, 7'b0000001, 0, K_TRAP, 4'b0000, 1'b0);
        do_reset;
        run(7'b0110011, 3'b000, 7'b0100000, 0, K_ALU, 4'b0110, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
